// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the line-fill memory server
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int LINE_BITS        = 128;
    localparam int WORD_BITS        = 32;
    localparam int WORDS_PER_LINE   = 4;
    localparam int OFFSET_BITS      = 2;
    localparam int BYTE_OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        READ = 3'd2,
        RESP = 3'd3,
        HOLD = 3'd4
    } state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
//  Module      : word_ram
//  Description : MEM_WORDS x 32 single-clock RAM, one synchronous read port
//                and one write port. A read and write to the same word in
//                the same cycle returns the old contents.
//  Revision    : 1.0  initial release
// ============================================================================
module word_ram
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rd_en_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [WORD_BITS-1:0] rd_data_o,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [WORD_BITS-1:0] wr_data_i
);

    logic [WORD_BITS-1:0] mem_q [MEM_WORDS];
    logic [WORD_BITS-1:0] rd_data_q;

    // Array write and registered read; non-blocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : word_ram
`default_nettype wire

// File: rtl/mem_line_server.sv
`default_nettype none
// ============================================================================
//  Module      : mem_line_server
//  Description : Main-memory responder for the I-cache line-fill handshake.
//                Reads four consecutive words after an access delay, packs
//                them into a 128-bit line and pulses mem_ready_o for one
//                cycle. Backdoor port loads the word RAM. rst is active low
//                and asynchronous.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_line_server
    import mem_pkg::*;
#(
    parameter int MEM_WORDS      = 4096,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req_i,
    input  logic [31:0]                  mem_addr_i,
    output logic [LINE_BITS-1:0]         mem_data_o,
    output logic                         mem_ready_o,
    input  logic                         ld_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr_i,
    input  logic [WORD_BITS-1:0]         ld_data_i,
    output logic                         busy_o
);

    localparam int AW        = $clog2(MEM_WORDS);
    localparam int BASE_W    = 32 - BYTE_OFFSET_BITS;
    localparam int WADDR_W   = BASE_W + OFFSET_BITS;
    localparam int WAIT_W    = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (ACCESS_LATENCY > 0) ? WAIT_W'(ACCESS_LATENCY - 1) : '0;
    // Beat 4 issues nothing; it only captures the last word from the RAM.
    localparam logic [2:0] LAST_BEAT = 3'd4;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]          beat_q, beat_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [LINE_BITS-1:0] mem_data_q;

    logic                w_rd_en;
    logic [WADDR_W-1:0]  w_word_addr_full;
    logic [AW-1:0]       w_rd_addr;
    logic [WORD_BITS-1:0] w_rd_data;
    logic [1:0]          w_slot;
    logic                w_capture;
    logic                w_unused;

    // Byte offset and RAM-wrapped upper address bits are intentionally dropped
    assign w_unused = ^{mem_addr_i[BYTE_OFFSET_BITS-1:0], (w_word_addr_full >> AW)};

    assign w_word_addr_full = {base_q, beat_q[OFFSET_BITS-1:0]};
    assign w_rd_addr        = w_word_addr_full[AW-1:0];
    // Data returned now was issued on the previous beat
    assign w_slot           = beat_q[1:0] - 2'd1;
    assign w_capture        = (state_q == READ) && (beat_q != 3'd0);

    word_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_word_ram (
        .clk       (clk),
        .rd_en_i   (w_rd_en),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data),
        .wr_en_i   (ld_en_i),
        .wr_addr_i (ld_addr_i),
        .wr_data_i (ld_data_i)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            beat_q     <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        base_d     = base_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                beat_d     = '0;
                if (mem_req_i) begin
                    base_d = mem_addr_i[31:BYTE_OFFSET_BITS];
                    if (ACCESS_LATENCY == 0) begin
                        state_d = READ;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!mem_req_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    state_d = READ;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            READ: begin
                if (!mem_req_i) begin
                    state_d = IDLE;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            RESP: begin
                state_d = mem_req_i ? HOLD : IDLE;
            end
            HOLD: begin
                if (!mem_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        mem_ready_o = (state_q == RESP);
        busy_o      = (state_q != IDLE);
        w_rd_en     = (state_q == READ) && (beat_q != LAST_BEAT);
    end

    // Line assembly: each returned word lands in its slot, held until overwritten
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data_q <= '0;
        end else if (w_capture) begin
            mem_data_q[{w_slot, 5'b00000} +: WORD_BITS] <= w_rd_data;
        end
    end

    assign mem_data_o = mem_data_q;

endmodule : mem_line_server
`default_nettype wire

// File: tb/tb_mem_line_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_line_server
//  Description : Self-checking bench for mem_line_server. Instance A uses the
//                default geometry (4096 words, latency 2); instance B uses
//                16 words and latency 0 to exercise wrap and zero delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_line_server;

    localparam int AL_A = 2;
    localparam int AL_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;
    logic [127:0] exp_q [$];

    logic         req_a = 1'b0;
    logic [31:0]  addr_a = '0;
    logic         ld_en_a = 1'b0;
    logic [11:0]  ld_addr_a = '0;
    logic [31:0]  ld_data_a = '0;
    logic [127:0] data_a;
    logic         ready_a;
    logic         busy_a;

    logic         req_b = 1'b0;
    logic [31:0]  addr_b = '0;
    logic         ld_en_b = 1'b0;
    logic [3:0]   ld_addr_b = '0;
    logic [31:0]  ld_data_b = '0;
    logic [127:0] data_b;
    logic         ready_b;
    logic         busy_b;

    mem_line_server #(.MEM_WORDS(4096), .ACCESS_LATENCY(AL_A)) dut_a (
        .clk(clk), .rst(rst), .mem_req_i(req_a), .mem_addr_i(addr_a),
        .mem_data_o(data_a), .mem_ready_o(ready_a), .ld_en_i(ld_en_a),
        .ld_addr_i(ld_addr_a), .ld_data_i(ld_data_a), .busy_o(busy_a)
    );

    mem_line_server #(.MEM_WORDS(16), .ACCESS_LATENCY(AL_B)) dut_b (
        .clk(clk), .rst(rst), .mem_req_i(req_b), .mem_addr_i(addr_b),
        .mem_data_o(data_b), .mem_ready_o(ready_b), .ld_en_i(ld_en_b),
        .ld_addr_i(ld_addr_b), .ld_data_i(ld_data_b), .busy_o(busy_b)
    );

    // Backdoor write of one word; starts and ends on a falling edge
    task automatic load(input bit sel, input int a, input logic [31:0] d);
        if (sel) begin
            ld_en_b = 1'b1; ld_addr_b = a[3:0]; ld_data_b = d;
        end else begin
            ld_en_a = 1'b1; ld_addr_a = a[11:0]; ld_data_a = d;
        end
        @(negedge clk);
        ld_en_a = 1'b0;
        ld_en_b = 1'b0;
    endtask

    // One complete fill; called right after a falling edge, returns on one.
    // inj_off >= 0 fires a backdoor write on instance A at edge S+inj_off+1.
    task automatic run_fill(input bit sel, input logic [31:0] a, input logic [127:0] exp,
                            input int hold, input int inj_off, input logic [11:0] inj_addr,
                            input logic [31:0] inj_data, input string name);
        int s_edge;
        int lat_exp;
        bit seen;
        logic [127:0] e;
        lat_exp = sel ? AL_B + 5 : AL_A + 5;
        if (sel) begin req_b = 1'b1; addr_b = a; end
        else     begin req_a = 1'b1; addr_a = a; end
        s_edge = cyc + 1;
        exp_q.push_back(exp);
        seen = 1'b0;
        e = exp;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            ld_en_a = 1'b0;
            if (inj_off >= 0 && cyc == s_edge + inj_off) begin
                ld_en_a = 1'b1; ld_addr_a = inj_addr; ld_data_a = inj_data;
            end
            if (sel ? ready_b : ready_a) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                n_vec++;
                if ((sel ? data_b : data_a) !== e) begin
                    n_mis++;
                    $display("FAIL %s line: got %h expected %h", name, sel ? data_b : data_a, e);
                end
                n_vec++;
                if (cyc - s_edge !== lat_exp) begin
                    n_mis++;
                    $display("FAIL %s latency: got S+%0d expected S+%0d", name, cyc - s_edge, lat_exp);
                end
            end else begin
                if (sel) addr_b = $urandom(); else addr_a = $urandom();
            end
        end
        ld_en_a = 1'b0;
        if (!seen) begin
            n_vec++; n_mis++;
            $display("FAIL %s timeout: no mem_ready within 40 cycles", name);
            exp_q.delete();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if ((sel ? ready_b : ready_a) !== 1'b0 || (sel ? busy_b : busy_a) !== 1'b1 ||
                (sel ? data_b : data_a) !== e) begin
                n_mis++;
                $display("FAIL %s hold%0d: ready=%b busy=%b data=%h expected ready=0 busy=1 data=%h",
                         name, i, sel ? ready_b : ready_a, sel ? busy_b : busy_a,
                         sel ? data_b : data_a, e);
            end
        end
        if (sel) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        n_vec++;
        if ((sel ? busy_b : busy_a) !== 1'b0 || (sel ? ready_b : ready_a) !== 1'b0) begin
            n_mis++;
            $display("FAIL %s release: busy=%b ready=%b expected 0 0", name,
                     sel ? busy_b : busy_a, sel ? ready_b : ready_a);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (ready_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 128'd0) begin
            n_mis++;
            $display("FAIL reset_a: ready=%b busy=%b data=%h expected 0 0 0", ready_a, busy_a, data_a);
        end
        n_vec++;
        if (ready_b !== 1'b0 || busy_b !== 1'b0 || data_b !== 128'd0) begin
            n_mis++;
            $display("FAIL reset_b: ready=%b busy=%b data=%h expected 0 0 0", ready_b, busy_b, data_b);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) load(1'b0, 32'h40 + i, 32'hA000_0000 + i);
        for (int i = 0; i < 4; i++) load(1'b0, 32'h80 + i, 32'hB000_0000 + i);
        for (int i = 0; i < 4; i++) load(1'b0, 32'hC0 + i, 32'hC000_0000 + i);
        run_fill(1'b0, 32'h100, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                 0, -1, 12'h0, 32'h0, "basic");
    endtask

    task automatic test_misaligned();
        run_fill(1'b0, 32'h10C, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                 0, -1, 12'h0, 32'h0, "misaligned");
    endtask

    task automatic test_back_to_back();
        run_fill(1'b0, 32'h100, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                 3, -1, 12'h0, 32'h0, "held");
        run_fill(1'b0, 32'h200, {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000},
                 0, -1, 12'h0, 32'h0, "refill");
    endtask

    task automatic test_abort();
        int pulses;
        req_a = 1'b1; addr_a = 32'h100;
        repeat (4) @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_mis++;
            $display("FAIL abort_busy_before: got %b expected 1", busy_a);
        end
        req_a = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_busy_after: got %b expected 0", busy_a);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_mis++;
            $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
        end
        run_fill(1'b0, 32'h100, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                 0, -1, 12'h0, 32'h0, "after_abort");
    endtask

    task automatic test_wrap();
        load(1'b1, 0, 32'h0000_0055);
        load(1'b1, 1, 32'h0000_0066);
        load(1'b1, 2, 32'h0000_0077);
        load(1'b1, 3, 32'h0000_0088);
        run_fill(1'b1, 32'h40, {32'h00000088, 32'h00000077, 32'h00000066, 32'h00000055},
                 0, -1, 12'h0, 32'h0, "wrap_zero_lat");
    endtask

    task automatic test_reset_midfill();
        int pulses;
        req_a = 1'b1; addr_a = 32'h200;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0 || data_a !== 128'd0) begin
            n_mis++;
            $display("FAIL midfill_reset: busy=%b ready=%b data=%h expected 0 0 0", busy_a, ready_a, data_a);
        end
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready_a === 1'b1 || busy_a === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_mis++;
            $display("FAIL midfill_quiet: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_same_cycle_load();
        // Write word 0xC1 on the edge that reads it: old value expected
        run_fill(1'b0, 32'h300, {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000},
                 0, 3, 12'hC1, 32'hDEAD_BEEF, "rbw_old");
        run_fill(1'b0, 32'h300, {32'hC0000003, 32'hC0000002, 32'hDEADBEEF, 32'hC0000000},
                 0, -1, 12'h0, 32'h0, "rbw_new");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_reset_midfill();
        test_same_cycle_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_mem_line_server
`default_nettype wire
